// File: rtl/osc_wave_render.sv
// osc_wave_render: VGA timing generator and oscilloscope trace plotter fed from the capture RAM.
// Optional macro OSC_VLINE_EN draws the trace as a connected vertical-line plot (default: dot plot).
module osc_wave_render #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int WAVE_TOP = 112,
  parameter int DEPTH    = 8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        show_en,
  input  logic [1:0]  show_sel,
  input  logic [12:0] show_addr,
  input  logic        result_out,
  input  logic [7:0]  sel_data_in,
  output logic [12:0] ram_raddr,
  input  logic [7:0]  ram_rdata,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [15:0] vga_rgb,
  output logic        vga_rdy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [7:0]  DIV_LAST = 8'(PIX_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_RDY    = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  H_CTR    = 10'(H_ACTIVE / 2);
  localparam logic [9:0]  WT10     = 10'(WAVE_TOP);
  localparam logic [10:0] WIN_BEG  = 11'(WAVE_TOP);
  localparam logic [10:0] WIN_END  = 11'(WAVE_TOP + 256);
  localparam logic [13:0] DEPTH_W  = 14'(DEPTH);

  // Per-pixel attributes carried alongside the RAM read so colour and syncs stay aligned.
  typedef struct packed {
    logic       act;
    logic       win;
    logic [7:0] row;
    logic       ctr;
    logic       grid;
    logic       hsa;
    logic       vsa;
`ifdef OSC_VLINE_EN
    logic       col0;
`endif
  } pix_t;

  logic [7:0]  div_q, div_d;
  logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [12:0] base_q, base_d;
  logic [1:0]  sel_q, sel_d;
  logic        en_q, en_d, mark_q, mark_d;
  logic [7:0]  thr_q, thr_d;
  logic [12:0] raddr_q, raddr_d;
  pix_t        p1_q, p1_d, p2_q, p2_d, pix_s;
  logic [7:0]  sample_q, sample_d;
  logic [15:0] rgb_q, rgb_d, rgb_s;
  logic        hs_q, hs_d, vs_q, vs_d, rdy_q, rdy_d;

  logic        pix_en_s, origin_s, hact_s, vwin_s, trace_s, mark_s, show_s;
  logic [12:0] base_cur_s, addr_wrap_s;
  logic [13:0] addr_sum_s;
  logic [7:0]  wy_s;

  assign pix_en_s    = (div_q == DIV_LAST);
  assign origin_s    = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  assign hact_s      = (hcnt_q < H_ACT);
  // The origin pixel uses the incoming address so column 0 already sees the new frame's base.
  assign base_cur_s  = origin_s ? show_addr : base_q;
  assign addr_sum_s  = {1'b0, base_cur_s} + {4'b0, hcnt_q};
  assign addr_wrap_s = (addr_sum_s >= DEPTH_W) ? 13'(addr_sum_s - DEPTH_W) : addr_sum_s[12:0];
  assign vwin_s      = ({1'b0, vcnt_q} >= WIN_BEG) && ({1'b0, vcnt_q} < WIN_END);
  assign wy_s        = 8'(vcnt_q - WT10);

  always_comb begin
    pix_s      = '0;
    pix_s.act  = hact_s && (vcnt_q < V_ACT);
    pix_s.win  = vwin_s;
    pix_s.row  = ~wy_s;
    pix_s.ctr  = (hcnt_q == H_CTR);
    pix_s.grid = (hcnt_q[5:0] == 6'd0) || (vwin_s && (wy_s[4:0] == 5'd0));
    pix_s.hsa  = (hcnt_q >= HS_BEG) && (hcnt_q < HS_END);
    pix_s.vsa  = (vcnt_q >= VS_BEG) && (vcnt_q < VS_END);
`ifdef OSC_VLINE_EN
    pix_s.col0 = (hcnt_q == 10'd0);
`endif
  end

`ifdef OSC_VLINE_EN
  logic [7:0] prev_q, prev_d, lo_s, hi_s;
  assign lo_s    = (p2_q.col0 || (sample_q < prev_q)) ? sample_q : prev_q;
  assign hi_s    = (p2_q.col0 || (sample_q > prev_q)) ? sample_q : prev_q;
  assign trace_s = p2_q.win && (lo_s <= p2_q.row) && (p2_q.row <= hi_s);
`else
  assign trace_s = p2_q.win && (sample_q == p2_q.row);
`endif

  assign mark_s = p2_q.win && mark_q && (p2_q.row == thr_q);
  assign show_s = p2_q.act && en_q && (sel_q != 2'b00);

  always_comb begin
    rgb_s = 16'h0000;
    if (!show_s)                     rgb_s = 16'h0000;
    else if (sel_q[1] && trace_s)    rgb_s = 16'hFFE0;
    else if (mark_s)                 rgb_s = 16'hF800;
    else if (sel_q[0] && p2_q.ctr)   rgb_s = 16'h07FF;
    else if (sel_q[0] && p2_q.grid)  rgb_s = 16'h4208;
    else                             rgb_s = 16'h0000;
  end

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    base_d   = base_q;
    sel_d    = sel_q;
    en_d     = en_q;
    thr_d    = thr_q;
    mark_d   = mark_q;
    raddr_d  = raddr_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    sample_d = sample_q;
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    rdy_d    = 1'b0;
`ifdef OSC_VLINE_EN
    prev_d   = prev_q;
`endif
    if (pix_en_s) begin
      hcnt_d = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
      if (hcnt_q == H_LAST) vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      else                  vcnt_d = vcnt_q;
      if (origin_s) begin
        base_d = show_addr;
        sel_d  = show_sel;
        en_d   = show_en;
        thr_d  = sel_data_in;
        mark_d = result_out;
      end else begin
        base_d = base_q;
      end
      raddr_d  = hact_s ? addr_wrap_s : raddr_q;
      p1_d     = pix_s;
      p2_d     = p1_q;
      sample_d = ram_rdata;
      rgb_d    = rgb_s;
      hs_d     = ~p2_q.hsa;
      vs_d     = ~p2_q.vsa;
      rdy_d    = (vcnt_q == V_RDY) && (hcnt_q == H_LAST);
`ifdef OSC_VLINE_EN
      prev_d   = sample_q;
`endif
    end else begin
      rdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= 8'd0;
      hcnt_q   <= 10'd0;
      vcnt_q   <= 10'd0;
      base_q   <= 13'd0;
      sel_q    <= 2'd0;
      en_q     <= 1'b0;
      thr_q    <= 8'd0;
      mark_q   <= 1'b0;
      raddr_q  <= 13'd0;
      p1_q     <= '0;
      p2_q     <= '0;
      sample_q <= 8'd0;
      rgb_q    <= 16'h0000;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      rdy_q    <= 1'b0;
`ifdef OSC_VLINE_EN
      prev_q   <= 8'd0;
`endif
    end else begin
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      base_q   <= base_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      thr_q    <= thr_d;
      mark_q   <= mark_d;
      raddr_q  <= raddr_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      sample_q <= sample_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      rdy_q    <= rdy_d;
`ifdef OSC_VLINE_EN
      prev_q   <= prev_d;
`endif
    end
  end

  assign ram_raddr = raddr_q;
  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;
  assign vga_rgb   = rgb_q;
  assign vga_rdy   = rdy_q;

endmodule

// File: tb/tb_osc_wave_render.sv
// Directed bench for osc_wave_render on a shrunken 40x25 raster (32x20 active, plot window from row 4).
module tb_osc_wave_render;

  localparam int HT = 40;
  localparam int VT = 25;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        show_en, result_out;
  logic [1:0]  show_sel;
  logic [12:0] show_addr, ram_raddr;
  logic [7:0]  sel_data_in, ram_rdata, ram_flat;
  logic        vga_hs, vga_vs, vga_rdy;
  logic [15:0] vga_rgb;
  int          ram_mode;

  int n_checks = 0;
  int n_errors = 0;
  int ecnt = 0;
  int rdy_cnt = 0;
  int rdy_e[$];
  logic [15:0] exp_fill;

  logic [15:0] cap_rgb  [0:1][0:VT-1][0:HT-1];
  logic        cap_hs   [0:1][0:VT-1][0:HT-1];
  logic        cap_vs   [0:1][0:VT-1][0:HT-1];
  logic [12:0] cap_addr [0:1][0:VT-1][0:HT-1];

  osc_wave_render #(
    .PIX_DIV(2), .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(2), .WAVE_TOP(4), .DEPTH(8000)
  ) dut (
    .clk(clk), .rst(rst), .show_en(show_en), .show_sel(show_sel), .show_addr(show_addr),
    .result_out(result_out), .sel_data_in(sel_data_in), .ram_raddr(ram_raddr),
    .ram_rdata(ram_rdata), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb), .vga_rdy(vga_rdy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_val(input logic [12:0] a);
    case (ram_mode)
      0:       return a[7:0];
      1:       return ram_flat;
      default: return (a < 13'd8) ? 8'd240 : 8'd250;
    endcase
  endfunction

  always @(posedge clk) ram_rdata <= ram_val(ram_raddr);

  // Edge counter since reset release; S1 of pixel k lands on edge 2k+2, its output on edge 2k+6.
  always @(negedge clk) begin
    int ka, ko;
    if (rst) begin
      ecnt = 0;
    end else begin
      ecnt = ecnt + 1;
      if (ecnt >= 2 && ecnt % 2 == 0) begin
        ka = (ecnt - 2) / 2;
        cap_addr[(ka / FR) % 2][(ka % FR) / HT][ka % HT] = ram_raddr;
      end
      if (ecnt >= 6 && ecnt % 2 == 0) begin
        ko = (ecnt - 6) / 2;
        cap_rgb[(ko / FR) % 2][(ko % FR) / HT][ko % HT] = vga_rgb;
        cap_hs[(ko / FR) % 2][(ko % FR) / HT][ko % HT]  = vga_hs;
        cap_vs[(ko / FR) % 2][(ko % FR) / HT][ko % HT]  = vga_vs;
      end
      if (vga_rdy) begin
        rdy_cnt = rdy_cnt + 1;
        rdy_e.push_back(ecnt);
      end
    end
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ecnt(input int n);
    int guard;
    guard = 0;
    while (ecnt < n && guard < 4000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (ecnt < n) check_val("wait_timeout", ecnt, n);
  endtask

  function automatic int px(input int s, input int v, input int h);
    return int'(cap_rgb[s][v][h]);
  endfunction

  function automatic int ad(input int s, input int v, input int h);
    return int'(cap_addr[s][v][h]);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hs"}, int'(vga_hs), 1);
    check_val({tag, "_vs"}, int'(vga_vs), 1);
    check_val({tag, "_rgb"}, int'(vga_rgb), 0);
    check_val({tag, "_rdy"}, int'(vga_rdy), 0);
    check_val({tag, "_raddr"}, int'(ram_raddr), 0);
  endtask

  initial begin
    int n;
`ifdef OSC_VLINE_EN
    exp_fill = 16'hFFE0;
`else
    exp_fill = 16'h0000;
`endif
    rst = 1'b1; show_en = 1'b1; show_sel = 2'd2; show_addr = 13'd3824;
    result_out = 1'b0; sel_data_in = 8'd0; ram_mode = 0; ram_flat = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    #1 rst = 1'b0;

    // Frame 0: ramp RAM, base 3824 -> column x holds 240+x, trace row 19-x.
    wait_ecnt(2010);
    check_val("f0_addr_x0", ad(0, 5, 0), 3824);
    check_val("f0_addr_x31", ad(0, 5, 31), 3855);
    check_val("f0_addr_hold", ad(0, 5, 35), 3855);
    check_val("f0_trace_x0", px(0, 19, 0), 16'hFFE0);
    check_val("f0_trace_x7", px(0, 12, 7), 16'hFFE0);
    check_val("f0_trace_x15", px(0, 4, 15), 16'hFFE0);
    check_val("f0_off_x7", px(0, 11, 7), 0);
    check_val("f0_off_x9", px(0, 12, 9), 0);
    check_val("f0_nogrid", px(0, 4, 0), 0);
    check_val("f0_x16_fill", px(0, 10, 16), exp_fill);
    check_val("f0_blank_h", px(0, 5, 35), 0);
    check_val("f0_blank_v", px(0, 22, 3), 0);
    check_val("hs_lead", int'(cap_hs[0][3][33]), 1);
    check_val("hs_first", int'(cap_hs[0][3][34]), 0);
    check_val("hs_last", int'(cap_hs[0][3][37]), 0);
    check_val("hs_trail", int'(cap_hs[0][3][38]), 1);
    n = 0;
    for (int h = 0; h < HT; h++) if (cap_hs[0][7][h] == 1'b0) n++;
    check_val("hs_low_cnt", n, 4);
    check_val("vs_lead", int'(cap_vs[0][20][39]), 1);
    check_val("vs_first", int'(cap_vs[0][21][0]), 0);
    check_val("vs_last", int'(cap_vs[0][22][39]), 0);
    check_val("vs_trail", int'(cap_vs[0][23][0]), 1);
    n = 0;
    for (int v = 0; v < VT; v++)
      for (int h = 0; h < HT; h++) if (cap_vs[0][v][h] == 1'b0) n++;
    check_val("vs_low_cnt", n, 80);
    check_val("rdy_first", (rdy_e.size() > 0) ? rdy_e[0] : -1, 1600);

    // Mid-frame change: must not reach frame 1.
    show_addr = 13'd7990; show_sel = 2'd3;
    wait_ecnt(4010);
    check_val("f1_latch_trace", px(1, 12, 7), 16'hFFE0);
    check_val("f1_latch_nogrid", px(1, 4, 0), 0);
    check_val("f1_latch_addr", ad(1, 5, 3), 3827);
    check_val("rdy_second", (rdy_e.size() > 1) ? rdy_e[1] : -1, 3600);

    // Frame 2: base 7990 wraps between columns 9 and 10; grid + centre visible.
    wait_ecnt(5610);
    check_val("wrap_x9", ad(0, 5, 9), 7999);
    check_val("wrap_x10", ad(0, 5, 10), 0);
    check_val("wrap_x11", ad(0, 5, 11), 1);
    check_val("grid_row", px(0, 4, 5), 16'h4208);
    check_val("grid_col", px(0, 10, 0), 16'h4208);
    check_val("grid_col_top", px(0, 2, 0), 16'h4208);
    check_val("centre_row4", px(0, 4, 16), 16'h07FF);
    check_val("centre_mid", px(0, 10, 16), 16'h07FF);
    check_val("grid_empty", px(0, 10, 5), 0);
    result_out = 1'b1; sel_data_in = 8'd250; ram_mode = 1; ram_flat = 8'd250;

    // Frame 3: trace and marker coincide on row 9, trace wins.
    wait_ecnt(7610);
    check_val("mk_same_x5", px(1, 9, 5), 16'hFFE0);
    check_val("mk_same_x0", px(1, 9, 0), 16'hFFE0);
    check_val("mk_same_x16", px(1, 9, 16), 16'hFFE0);
    check_val("mk_same_row8", px(1, 8, 5), 0);
    ram_flat = 8'd240;

    // Frame 4: marker row 9 red over grid/centre, trace row 19.
    wait_ecnt(9610);
    check_val("mk_red_x5", px(0, 9, 5), 16'hF800);
    check_val("mk_red_x0", px(0, 9, 0), 16'hF800);
    check_val("mk_red_x16", px(0, 9, 16), 16'hF800);
    check_val("mk_trace_x5", px(0, 19, 5), 16'hFFE0);
    show_en = 1'b0;

    // Frame 5: show_en low blanks everything, timing keeps running.
    wait_ecnt(11610);
    check_val("en0_trace", px(1, 19, 5), 0);
    check_val("en0_marker", px(1, 9, 5), 0);
    check_val("en0_centre", px(1, 4, 16), 0);
    check_val("en0_hs", int'(cap_hs[1][3][35]), 0);
    check_val("rdy_count", rdy_cnt, 6);
    show_en = 1'b1; ram_mode = 2; show_addr = 13'd0;

    // Frame 6: reset in the middle of line 10 while the grid pixel x=0 is on the output.
    wait_ecnt(12806);
    check_val("pre_rst_rgb", int'(vga_rgb), 16'h4208);
    check_val("pre_rst_raddr", int'(ram_raddr), 2);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    rdy_e.delete();
    show_sel = 2'd2;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Post-reset frame from (0,0): step 240 -> 250 between columns 7 and 8.
    wait_ecnt(2010);
    check_val("pr_addr_x7", ad(0, 5, 7), 7);
    check_val("pr_addr_x31", ad(0, 5, 31), 31);
    check_val("pr_low_x3", px(0, 19, 3), 16'hFFE0);
    check_val("pr_high_x9", px(0, 9, 9), 16'hFFE0);
    check_val("pr_step_fill", px(0, 12, 8), exp_fill);
    check_val("pr_step_x9", px(0, 12, 9), 0);
    check_val("pr_col0", px(0, 12, 0), 0);
    check_val("pr_nocentre", px(0, 4, 16), 0);
    check_val("pr_rdy", (rdy_e.size() > 0) ? rdy_e[0] : -1, 1600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
